image_stream_reader: RTL and testbench

Streaming read engine that sits directly downstream of the 1024×8 on-chip image memory. On a start pulse it sweeps a contiguous window of that memory through the memory's read port and emits one byte per beat on a ready/valid pixel stream with start/end-of-frame markers. The memory has fixed one-cycle read latency, so credit-based issue and a small FIFO absorb downstream backpressure without losing data.

---
 rtl/image_stream_reader.sv | 149 ++++++++++++++
 tb/tb_image_stream_reader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/image_stream_reader.sv
// image_stream_reader: sweeps a contiguous window of the 1-cycle-latency image
// memory and emits it as a framed byte stream, with credit-based read issue
// and a small FIFO so downstream backpressure never drops a byte.
module image_stream_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int FRAME_LEN  = 1024,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W + 1)'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  DEPTH    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t state, state_next;

  logic [ADDR_W:0]   issue_count;
  logic              inflight;
  logic              inflight_sop;
  logic              inflight_eop;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic              fifo_sop  [FIFO_DEPTH];
  logic              fifo_eop  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  occupancy;

  logic push;
  logic pop;
  logic frame_end;

  // Credits: a read may only go out if its byte is guaranteed a FIFO slot,
  // counting the byte already on its way back from the memory.
  always_comb begin
    occupancy   = fifo_count + CNT_W'(inflight);
    mem_read    = (state == ISSUE) && (occupancy < DEPTH);
    mem_address = BASE + issue_count[ADDR_W-1:0];
    busy        = (state != IDLE);
    out_valid   = (fifo_count != '0);
    out_data    = out_valid ? fifo_data[rd_ptr] : '0;
    out_sop     = out_valid & fifo_sop[rd_ptr];
    out_eop     = out_valid & fifo_eop[rd_ptr];
    push        = inflight;
    pop         = out_valid & out_ready;
    frame_end   = (state == DRAIN) && pop && out_eop &&
                  (fifo_count == CNT_W'(1)) && !inflight;
  end

  // Next-state logic; abort overrides everything and start is ignored
  // during the done pulse so a frame cannot be re-triggered back to back.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start && !done) state_next = ISSUE;
      ISSUE:   if (mem_read && (issue_count == LAST_IDX)) state_next = DRAIN;
      DRAIN:   if (frame_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // State register and the one-cycle done pulse on a completed frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= frame_end & ~abort;
    end
  end

  // Read issue counter plus the tag of the read currently in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_count  <= '0;
      inflight     <= 1'b0;
      inflight_sop <= 1'b0;
      inflight_eop <= 1'b0;
    end else if (abort) begin
      issue_count  <= '0;
      inflight     <= 1'b0;
      inflight_sop <= 1'b0;
      inflight_eop <= 1'b0;
    end else begin
      inflight     <= mem_read;
      inflight_sop <= (issue_count == '0);
      inflight_eop <= (issue_count == LAST_IDX);
      if (frame_end) begin
        issue_count <= '0;
      end else if (mem_read) begin
        issue_count <= issue_count + (ADDR_W + 1)'(1);
      end
    end
  end

  // FIFO pointers and occupancy; abort empties the buffer in one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  // FIFO storage; contents are only visible through the gated outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_readdata;
      fifo_sop[wr_ptr]  <= inflight_sop;
      fifo_eop[wr_ptr]  <= inflight_eop;
    end
  end

endmodule

// File: tb/tb_image_stream_reader.sv
// Directed bench for image_stream_reader: three instances (full 1024-byte
// frame, 8-byte frame wrapping the top of memory, 1-byte frame), each fed by
// a memory model whose data is address[7:0].
module tb_image_stream_reader;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       st  [N];
  logic       ab  [N];
  logic       rdy [N];
  logic       bz  [N];
  logic       dn  [N];
  logic [9:0] ma  [N];
  logic       mr  [N];
  logic [7:0] od  [N];
  logic       ov  [N];
  logic       os  [N];
  logic       oe  [N];

  int vectors = 0;
  int miscompares = 0;

  int r_beats, r_bad_data, r_bad_sop, r_bad_eop, r_bad_addr, r_viol, r_hold;
  int r_first_valid, r_eop_cyc, r_done_cyc, r_done_cnt;
  int r_busy0, r_busy_done, r_busy_after;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [7:0] rdata;

    image_stream_reader #(
      .ADDR_W(10),
      .DATA_W(8),
      .FRAME_LEN(g == 0 ? 1024 : (g == 1 ? 8 : 1)),
      .BASE_ADDR(g == 1 ? 1020 : 0),
      .FIFO_DEPTH(4)
    ) u_dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(st[g]),
      .abort(ab[g]),
      .busy(bz[g]),
      .done(dn[g]),
      .mem_address(ma[g]),
      .mem_read(mr[g]),
      .mem_readdata(rdata),
      .out_data(od[g]),
      .out_valid(ov[g]),
      .out_ready(rdy[g]),
      .out_sop(os[g]),
      .out_eop(oe[g])
    );

    always @(posedge clk) begin
      if (mr[g]) rdata <= ma[g][7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input int d, input int len, input int base, input bit rand_ready,
                           input bit poke, input bit start_at_done);
    int cyc, pending, issued;
    logic hv, hs, he;
    logic [7:0] hd;
    r_beats = 0; r_bad_data = 0; r_bad_sop = 0; r_bad_eop = 0; r_bad_addr = 0;
    r_viol = 0; r_hold = 0; r_first_valid = -1; r_eop_cyc = -1; r_done_cyc = -1;
    r_done_cnt = 0; r_busy0 = 0; r_busy_done = 1; r_busy_after = 0;
    pending = 0; issued = 0; hv = 1'b0; hs = 1'b0; he = 1'b0; hd = '0;
    st[d] = 1'b1;
    rdy[d] = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (cyc < 4000) begin
      st[d] = poke && (cyc == 20);
      rdy[d] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 0) r_busy0 = int'(bz[d]);
      if (hv && (!ov[d] || od[d] !== hd || os[d] !== hs || oe[d] !== he)) r_hold++;
      if (mr[d]) begin
        if (pending >= 4) r_viol++;
        if (ma[d] !== 10'((base + issued) % 1024)) r_bad_addr++;
        issued++;
        pending++;
      end
      if (ov[d] && rdy[d]) begin
        if (od[d] !== 8'((base + r_beats) % 1024)) r_bad_data++;
        if (os[d] !== (r_beats == 0)) r_bad_sop++;
        if (oe[d] !== (r_beats == len - 1)) r_bad_eop++;
        if (r_beats == len - 1) r_eop_cyc = cyc;
        r_beats++;
        pending--;
      end
      hv = ov[d] && !rdy[d];
      hd = od[d]; hs = os[d]; he = oe[d];
      if (ov[d] && r_first_valid < 0) r_first_valid = cyc;
      if (r_done_cyc >= 0 && bz[d]) r_busy_after = 1;
      if (dn[d]) begin
        r_done_cnt++;
        if (r_done_cyc < 0) begin
          r_done_cyc = cyc;
          r_busy_done = int'(bz[d]);
          if (start_at_done) st[d] = 1'b1;
        end
      end
      if (r_done_cyc >= 0 && cyc >= r_done_cyc + 3) break;
      @(negedge clk);
      cyc++;
    end
    st[d] = 1'b0;
    rdy[d] = 1'b1;
  endtask

  task automatic check_frame(input string p, input int len, input bit exact);
    check({p, " beats"}, r_beats, len);
    check({p, " data_errs"}, r_bad_data, 0);
    check({p, " sop_errs"}, r_bad_sop, 0);
    check({p, " eop_errs"}, r_bad_eop, 0);
    check({p, " addr_errs"}, r_bad_addr, 0);
    check({p, " credit_viol"}, r_viol, 0);
    check({p, " hold_errs"}, r_hold, 0);
    check({p, " done_pulses"}, r_done_cnt, 1);
    check({p, " busy_at_c0"}, r_busy0, 1);
    check({p, " busy_at_done"}, r_busy_done, 0);
    check({p, " busy_after_done"}, r_busy_after, 0);
    check({p, " done_after_eop"}, r_done_cyc, r_eop_cyc + 1);
    if (exact) begin
      check({p, " first_valid_cyc"}, r_first_valid, 2);
      check({p, " done_cyc"}, r_done_cyc, len + 2);
    end
  endtask

  initial begin
    int beats, cyc, done_seen;
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      st[i] = 1'b0; ab[i] = 1'b0; rdy[i] = 1'b1;
    end

    // Reset values
    #12;
    check("rst busy", bz[0], 0);
    check("rst done", dn[0], 0);
    check("rst mem_read", mr[0], 0);
    check("rst mem_address", ma[0], 10'd0);
    check("rst wrap mem_address", ma[1], 10'd1020);
    check("rst out_valid", ov[0], 0);
    check("rst out_sop", os[0], 0);
    check("rst out_eop", oe[0], 0);
    check("rst out_data", od[0], 8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    // Full frame at full rate, start held during the done pulse
    run_frame(0, 1024, 0, 1'b0, 1'b0, 1'b1);
    check_frame("full", 1024, 1'b1);

    // Random backpressure, plus a start while busy
    run_frame(0, 1024, 0, 1'b1, 1'b1, 1'b0);
    check_frame("rand", 1024, 1'b0);

    // Window wrapping past the top of memory
    run_frame(1, 8, 1020, 1'b0, 1'b0, 1'b0);
    check_frame("wrap", 8, 1'b1);

    // Single-beat frame
    run_frame(2, 1, 0, 1'b0, 1'b0, 1'b0);
    check_frame("one", 1, 1'b1);

    // Abort with the FIFO full and downstream stalled at beat 100
    st[0] = 1'b1;
    rdy[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    beats = 0;
    cyc = 0;
    while (beats < 100 && cyc < 500) begin
      #1;
      if (ov[0] && rdy[0]) beats++;
      @(negedge clk);
      cyc++;
    end
    rdy[0] = 1'b0;
    check("abt beats_before", beats, 100);
    repeat (5) @(negedge clk);
    #1;
    check("abt full_valid", ov[0], 1);
    check("abt full_no_read", mr[0], 0);
    check("abt head_data", od[0], 8'h64);
    check("abt busy_before", bz[0], 1);
    ab[0] = 1'b1;
    @(negedge clk);
    ab[0] = 1'b0;
    #1;
    check("abt valid_after", ov[0], 0);
    check("abt busy_after", bz[0], 0);
    check("abt read_after", mr[0], 0);
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (dn[0]) done_seen++;
      @(negedge clk);
      #1;
    end
    check("abt no_done", done_seen, 0);
    st[0] = 1'b1;
    ab[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    ab[0] = 1'b0;
    #1;
    check("abt start_with_abort_busy", bz[0], 0);
    check("abt start_with_abort_read", mr[0], 0);
    rdy[0] = 1'b1;
    run_frame(0, 1024, 0, 1'b0, 1'b0, 1'b0);
    check_frame("restart", 1024, 1'b1);

    // Asynchronous reset in the middle of a frame
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (30) @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst busy", bz[0], 0);
    check("arst mem_read", mr[0], 0);
    check("arst mem_address", ma[0], 10'd0);
    check("arst out_valid", ov[0], 0);
    check("arst out_data", od[0], 8'h00);
    check("arst out_sop", os[0], 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_frame(0, 1024, 0, 1'b0, 1'b0, 1'b0);
    check_frame("post_rst", 1024, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
